// File: rtl/decade_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : decade_count_ctrl
// Brief    : Run/pause/stop controller around a cascade of BCD digit counters
//            with prescaled tick, BCD preload and terminal-count detection.
// Revision : 1.0 - initial release
// ============================================================================
module decade_count_ctrl #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_bcd,
    input  logic [4*DIGITS-1:0]   target_bcd,
    input  logic                  auto_reload,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [1:0]            state,
    output logic                  busy,
    output logic                  match,
    output logic                  wrap,
    output logic                  load_err
);

    localparam int          c_w        = 4 * DIGITS;
    localparam logic [15:0] c_tick_max = 16'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t         r_state, w_state;
    logic [c_w-1:0] r_count, w_count;
    logic [c_w-1:0] r_reload, w_reload;
    logic [15:0]    r_presc, w_presc;
    logic           r_match, w_match;
    logic           r_wrap, w_wrap;
    logic           r_load_err, w_load_err;

    logic [c_w-1:0] w_inc;
    logic           w_carry;
    logic [c_w-1:0] w_ld_clean;
    logic           w_ld_bad;

    // Ripple increment: each digit advances only while every lower digit was 9.
    always_comb begin
        w_inc   = r_count;
        w_carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_carry         = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_ld_clean = load_bcd;
        w_ld_bad   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_bcd[4*i +: 4] > 4'd9) begin
                w_ld_clean[4*i +: 4] = 4'd0;
                w_ld_bad             = 1'b1;
            end
        end
    end

    // Only the highest-priority active command acts; any command pre-empts a tick.
    always_comb begin
        w_state    = r_state;
        w_count    = r_count;
        w_reload   = r_reload;
        w_presc    = r_presc;
        w_match    = 1'b0;
        w_wrap     = 1'b0;
        w_load_err = 1'b0;
        if (clear) begin
            w_count = '0;
            w_presc = '0;
            w_state = S_IDLE;
        end else if (load) begin
            w_count    = w_ld_clean;
            w_reload   = w_ld_clean;
            w_presc    = '0;
            w_load_err = w_ld_bad;
        end else if (pause) begin
            if (r_state == S_RUN) begin
                w_state = S_PAUSE;
            end
        end else if (start) begin
            if (r_state != S_RUN) begin
                w_state = S_RUN;
                w_presc = '0;
            end
        end else if (r_state == S_RUN) begin
            if (r_presc == c_tick_max) begin
                w_presc = '0;
                w_wrap  = w_carry;
                w_count = w_inc;
                if (w_inc == target_bcd) begin
                    w_match = 1'b1;
                    if (auto_reload) begin
                        w_count = r_reload;
                    end else begin
                        w_state = S_DONE;
                    end
                end
            end else begin
                w_presc = r_presc + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_reload   <= '0;
            r_presc    <= '0;
            r_match    <= 1'b0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_count    <= w_count;
            r_reload   <= w_reload;
            r_presc    <= w_presc;
            r_match    <= w_match;
            r_wrap     <= w_wrap;
            r_load_err <= w_load_err;
        end
    end

    assign count_bcd = r_count;
    assign state     = r_state;
    assign busy      = (r_state == S_RUN);
    assign match     = r_match;
    assign wrap      = r_wrap;
    assign load_err  = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_decade_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_decade_count_ctrl
// Brief    : Directed bench for decade_count_ctrl (2 digits, prescale 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decade_count_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, pause, clear, load, auto_reload;
    logic [7:0] load_bcd, target_bcd;

    logic [7:0] cnt0, cnt1;
    logic [1:0] st0, st1;
    logic       busy0, match0, wrap0, lerr0;
    logic       busy1, match1, wrap1, lerr1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decade_count_ctrl #(.DIGITS(2), .TICK_DIV(1)) u_div1 (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
        .load(load), .load_bcd(load_bcd), .target_bcd(target_bcd),
        .auto_reload(auto_reload), .count_bcd(cnt0), .state(st0), .busy(busy0),
        .match(match0), .wrap(wrap0), .load_err(lerr0)
    );

    decade_count_ctrl #(.DIGITS(2), .TICK_DIV(3)) u_div3 (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
        .load(load), .load_bcd(load_bcd), .target_bcd(target_bcd),
        .auto_reload(auto_reload), .count_bcd(cnt1), .state(st1), .busy(busy1),
        .match(match1), .wrap(wrap1), .load_err(lerr1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse a single command for one edge.
    task automatic cmd_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask
    task automatic cmd_load(input logic [7:0] v);
        load_bcd = v; load = 1'b1; step(); load = 1'b0;
    endtask
    task automatic cmd_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    logic [7:0] exp_run [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                 8'h07, 8'h08, 8'h09, 8'h10, 8'h11, 8'h12};
    logic [7:0] exp_rl  [6]  = '{8'h06, 8'h07, 8'h05, 8'h06, 8'h07, 8'h05};
    logic       exp_rlm [6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] exp_pre [4]  = '{8'h00, 8'h00, 8'h01, 8'h01};
    logic [7:0] exp_res [6]  = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h03};

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; load = 1'b0;
        auto_reload = 1'b0; load_bcd = 8'h00; target_bcd = 8'h50;
        step(); step();
        chk("rst_count", {24'd0, cnt0}, 32'h00);
        chk("rst_state", {30'd0, st0}, 32'd0);
        chk("rst_flags", {28'd0, busy0, match0, wrap0, lerr0}, 32'd0);
        reset = 1'b0;

        // Free count from zero, prescale 1
        cmd_start();
        chk("start_count", {24'd0, cnt0}, 32'h00);
        chk("start_state", {30'd0, st0}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("run_count[%0d]", i), {24'd0, cnt0}, {24'd0, exp_run[i]});
            chk($sformatf("run_match[%0d]", i), {31'd0, match0}, 32'd0);
        end
        chk("run_busy", {31'd0, busy0}, 32'd1);

        // One-shot terminal count
        cmd_clear();
        chk("clear_state", {30'd0, st0}, 32'd0);
        chk("clear_count", {24'd0, cnt0}, 32'h00);
        target_bcd = 8'h99;
        cmd_load(8'h97);
        chk("load_count", {24'd0, cnt0}, 32'h97);
        chk("load_state", {30'd0, st0}, 32'd0);
        cmd_start();
        step();
        chk("os_98", {24'd0, cnt0}, 32'h98);
        chk("os_98_match", {31'd0, match0}, 32'd0);
        step();
        chk("os_99", {24'd0, cnt0}, 32'h99);
        chk("os_99_match", {31'd0, match0}, 32'd1);
        chk("os_done", {30'd0, st0}, 32'd3);
        chk("os_busy", {31'd0, busy0}, 32'd0);
        step();
        chk("os_hold", {24'd0, cnt0}, 32'h99);
        chk("os_match_drop", {31'd0, match0}, 32'd0);

        // Auto-reload: 05 -> 06 -> 07 -> (08 hidden) 05
        cmd_clear();
        target_bcd = 8'h08; auto_reload = 1'b1;
        cmd_load(8'h05);
        cmd_start();
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("ar_count[%0d]", i), {24'd0, cnt0}, {24'd0, exp_rl[i]});
            chk($sformatf("ar_match[%0d]", i), {31'd0, match0}, {31'd0, exp_rlm[i]});
        end
        chk("ar_state", {30'd0, st0}, 32'd1);

        // Unreachable target: rollover pulses wrap only
        auto_reload = 1'b0; target_bcd = 8'hAA;
        cmd_clear();
        cmd_load(8'h98);
        cmd_start();
        step();
        chk("wr_99", {24'd0, cnt0}, 32'h99);
        chk("wr_99_wrap", {31'd0, wrap0}, 32'd0);
        step();
        chk("wr_00", {24'd0, cnt0}, 32'h00);
        chk("wr_00_wrap", {31'd0, wrap0}, 32'd1);
        chk("wr_00_match", {31'd0, match0}, 32'd0);
        step();
        chk("wr_01", {24'd0, cnt0}, 32'h01);
        chk("wr_01_wrap", {31'd0, wrap0}, 32'd0);

        // Match and wrap on the same tick, then re-arm from DONE
        target_bcd = 8'h00;
        cmd_clear();
        cmd_load(8'h99);
        cmd_start();
        step();
        chk("mw_count", {24'd0, cnt0}, 32'h00);
        chk("mw_flags", {30'd0, match0, wrap0}, 32'd3);
        chk("mw_state", {30'd0, st0}, 32'd3);
        cmd_start();
        chk("rearm_state", {30'd0, st0}, 32'd1);
        chk("rearm_count", {24'd0, cnt0}, 32'h00);
        step();
        chk("rearm_next", {24'd0, cnt0}, 32'h01);

        // Bad nibble loads as zero and flags
        cmd_clear();
        cmd_load(8'h3C);
        chk("lerr_count", {24'd0, cnt0}, 32'h30);
        chk("lerr_pulse", {31'd0, lerr0}, 32'd1);
        step();
        chk("lerr_drop", {31'd0, lerr0}, 32'd0);

        // clear beats load
        cmd_load(8'h55);
        clear = 1'b1; load = 1'b1; load_bcd = 8'h77;
        step();
        clear = 1'b0; load = 1'b0;
        chk("clr_ld_count", {24'd0, cnt0}, 32'h00);
        chk("clr_ld_state", {30'd0, st0}, 32'd0);

        // Reset mid-run, then reload register must be zero again
        target_bcd = 8'h50;
        cmd_load(8'h40);
        cmd_start();
        step();
        chk("pre_rst_count", {24'd0, cnt0}, 32'h41);
        reset = 1'b1; step(); reset = 1'b0;
        chk("mid_rst_count", {24'd0, cnt0}, 32'h00);
        chk("mid_rst_state", {30'd0, st0}, 32'd0);
        chk("mid_rst_flags", {28'd0, busy0, match0, wrap0, lerr0}, 32'd0);
        auto_reload = 1'b1; target_bcd = 8'h02;
        cmd_start();
        step();
        chk("rr_01", {24'd0, cnt0}, 32'h01);
        step();
        chk("rr_reload0", {24'd0, cnt0}, 32'h00);
        chk("rr_match", {31'd0, match0}, 32'd1);
        auto_reload = 1'b0; target_bcd = 8'hAA;

        // Prescale 3 with pause/resume (second instance)
        cmd_clear();
        cmd_start();
        chk("p3_start", {24'd0, cnt1}, 32'h00);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("p3_pre[%0d]", i), {24'd0, cnt1}, {24'd0, exp_pre[i]});
        end
        pause = 1'b1; step(); pause = 1'b0;
        chk("p3_pause_state", {30'd0, st1}, 32'd2);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("p3_frozen[%0d]", i), {24'd0, cnt1}, 32'h01);
        end
        chk("p3_pause_busy", {31'd0, busy1}, 32'd0);
        cmd_start();
        chk("p3_resume_state", {30'd0, st1}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("p3_res[%0d]", i), {24'd0, cnt1}, {24'd0, exp_res[i]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
